song_reader: RTL and testbench



---
 rtl/song_pkg.sv | 57 +++++
 rtl/song_rom.sv | 35 +++
 rtl/song_reader.sv | 123 ++++++++++++
 tb/tb_song_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared definitions for the song reader: FSM state encoding, default
// field widths, the end-of-song marker and the note ROM contents.
package song_pkg;

  localparam int NOTE_BITS_DEF = 6;
  localparam int DUR_BITS_DEF  = 6;
  localparam int IDX_BITS_DEF  = 5;
  localparam int SONG_BITS     = 2;

  // A duration of zero never plays; it marks the end of a song.
  localparam int END_MARKER = 0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    END   = 3'd5
  } state_t;

  // Note ROM image. Song 0 is a short two-note tune, song 1 fills every
  // slot, song 2 ends after 12 notes and song 3 after 20 notes (slot 2 of
  // song 3 is a rest).
  function automatic int rom_note(input int song, input int idx);
    int r;
    r = 0;
    case (song)
      0: begin
        if (idx == 0) r = 'h10;
        else if (idx == 1) r = 'h12;
        else r = 0;
      end
      1: r = idx + 1;
      2: r = 'h12 + idx;
      default: r = (idx == 2) ? 0 : ('h30 ^ idx);
    endcase
    return r;
  endfunction

  function automatic int rom_dur(input int song, input int idx);
    int r;
    r = END_MARKER;
    case (song)
      0: begin
        if (idx == 0) r = 4;
        else if (idx == 1) r = 2;
        else r = END_MARKER;
      end
      1: r = (idx % 7) + 1;
      2: r = (idx < 12) ? (idx % 5) + 1 : END_MARKER;
      default: r = (idx < 20) ? 3 : END_MARKER;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read note ROM. Four songs of 2**IDX_BITS slots each, addressed
// as {song, index}; each word holds {note, duration}. Data appears one clock
// after a read is enabled and holds until the next enabled read.
module song_rom
  import song_pkg::*;
#(
  parameter int NOTE_BITS = NOTE_BITS_DEF,
  parameter int DUR_BITS  = DUR_BITS_DEF,
  parameter int IDX_BITS  = IDX_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rd_en,
  input  logic [SONG_BITS+IDX_BITS-1:0] addr,
  output logic [NOTE_BITS-1:0]          rd_note,
  output logic [DUR_BITS-1:0]           rd_dur
);

  localparam int SLOTS = 2 ** IDX_BITS;
  localparam int DEPTH = (2 ** SONG_BITS) * SLOTS;

  logic [NOTE_BITS+DUR_BITS-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_image
    assign mem[i] = {NOTE_BITS'(rom_note(i / SLOTS, i % SLOTS)),
                     DUR_BITS'(rom_dur(i / SLOTS, i % SLOTS))};
  end

  // Registered read port: one-cycle latency, output held between reads.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      {rd_note, rd_dur} <= mem[addr];
    end
  end

endmodule

// File: rtl/song_reader.sv
// Song reader: walks the selected song in the note ROM and hands one note
// at a time to the note player, advancing on note_done and reporting the
// end of the song with a single song_done pulse.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for play before fetching the note at index
//   FETCH | ROM address {song, index} presented; song sampled here
//   CHECK | ROM word valid; end marker -> DONE, else load note outputs
//   WAIT  | note being played; note_done advances (ignored on new_note cycle)
//   DONE  | issue the song_done pulse
//   END   | song finished; only reset_play or reset leaves
module song_reader
  import song_pkg::*;
#(
  parameter int NOTE_BITS = NOTE_BITS_DEF,
  parameter int DUR_BITS  = DUR_BITS_DEF,
  parameter int IDX_BITS  = IDX_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 play,
  input  logic                 reset_play,
  input  logic [SONG_BITS-1:0] song,
  input  logic                 note_done,
  output logic [NOTE_BITS-1:0] note,
  output logic [DUR_BITS-1:0]  duration,
  output logic                 new_note,
  output logic                 song_done
);

  localparam logic [IDX_BITS-1:0] IDX_MAX = '1;

  state_t                        state;
  logic [IDX_BITS-1:0]           index;
  logic [SONG_BITS+IDX_BITS-1:0] rom_addr;
  logic                          rom_rd_en;
  logic [NOTE_BITS-1:0]          rom_note_q;
  logic [DUR_BITS-1:0]           rom_dur_q;
  logic                          rom_is_end;
  logic                          last_slot;
  logic                          note_finished;

  assign rom_addr   = {song, index};
  // A restart in the FETCH cycle abandons the read, so don't launch it.
  assign rom_rd_en  = (state == FETCH) && !reset_play;
  assign rom_is_end = (rom_dur_q == DUR_BITS'(END_MARKER));
  assign last_slot  = (index == IDX_MAX);
  // The cycle new_note is high is the first WAIT cycle; a note_done there
  // belongs to the previous note and must not skip the one just issued.
  assign note_finished = note_done && !new_note;

  song_rom #(
    .NOTE_BITS (NOTE_BITS),
    .DUR_BITS  (DUR_BITS),
    .IDX_BITS  (IDX_BITS)
  ) u_rom (
    .clk     (clk),
    .rd_en   (rom_rd_en),
    .addr    (rom_addr),
    .rd_note (rom_note_q),
    .rd_dur  (rom_dur_q)
  );

  // Sequencing FSM with index counter and registered note/pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      index     <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else if (reset_play) begin
      state     <= IDLE;
      index     <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;
      case (state)
        IDLE: begin
          if (play) state <= FETCH;
        end
        FETCH: begin
          state <= CHECK;
        end
        CHECK: begin
          if (rom_is_end) begin
            state <= DONE;
          end else begin
            note     <= rom_note_q;
            duration <= rom_dur_q;
            new_note <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (note_finished) begin
            if (last_slot) begin
              state <= DONE;
            end else begin
              index <= index + 1'b1;
              state <= play ? FETCH : IDLE;
            end
          end
        end
        DONE: begin
          song_done <= 1'b1;
          state     <= END;
        end
        END: begin
          state <= END;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader.sv
// Bench for song_reader: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_song_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic       reset_play = 1'b0;
  logic       note_done = 1'b0;
  logic [1:0] song = 2'd0;
  logic [5:0] note;
  logic [5:0] duration;
  logic       new_note;
  logic       song_done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_on = 1'b0;
  int t0 = 0;

  int nn_cyc[$];
  int nn_note[$];
  int nn_dur[$];
  int sd_cyc[$];

  song_reader dut (
    .clk        (clk),
    .reset      (reset),
    .play       (play),
    .reset_play (reset_play),
    .song       (song),
    .note_done  (note_done),
    .note       (note),
    .duration   (duration),
    .new_note   (new_note),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Test content of the note ROM, as written down for each song.
  function automatic int ref_note(input int s, input int i);
    int r;
    r = 0;
    if (s == 0) begin
      if (i == 0) r = 16;
      if (i == 1) r = 18;
    end else if (s == 1) r = i + 1;
    else if (s == 2) r = 18 + i;
    else if (i != 2) r = 48 ^ i;
    return r;
  endfunction

  function automatic int ref_dur(input int s, input int i);
    int r;
    r = 0;
    if (s == 0) begin
      if (i == 0) r = 4;
      if (i == 1) r = 2;
    end else if (s == 1) r = 1 + (i % 7);
    else if (s == 2) begin
      if (i < 12) r = 1 + (i % 5);
    end else if (i < 20) r = 3;
    return r;
  endfunction

  // Behavioural model. Phases: idle, loading a note (2 clocks of fetch
  // latency, song captured on the first), playing, finishing, finished.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_PLAY = 2, PH_FINISH = 3, PH_OVER = 4;
  int m_ph = PH_IDLE;
  int m_idx = 0;
  int m_lat = 0;
  int m_song = 0;
  bit m_fresh = 1'b0;
  int e_note = 0;
  int e_dur = 0;
  bit e_new = 1'b0;
  bit e_done = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = PH_IDLE; m_idx = 0; m_lat = 0; m_fresh = 1'b0;
      e_note = 0; e_dur = 0; e_new = 1'b0; e_done = 1'b0;
    end else if (reset_play) begin
      m_ph = PH_IDLE; m_idx = 0; m_fresh = 1'b0;
      e_new = 1'b0; e_done = 1'b0;
    end else begin
      e_new = 1'b0;
      e_done = 1'b0;
      case (m_ph)
        PH_IDLE: if (play) begin m_ph = PH_LOAD; m_lat = 2; end
        PH_LOAD: begin
          if (m_lat == 2) begin
            m_song = int'(song);
            m_lat = 1;
          end else if (ref_dur(m_song, m_idx) == 0) begin
            m_ph = PH_FINISH;
          end else begin
            e_note = ref_note(m_song, m_idx);
            e_dur = ref_dur(m_song, m_idx);
            e_new = 1'b1;
            m_fresh = 1'b1;
            m_ph = PH_PLAY;
          end
        end
        PH_PLAY: begin
          if (m_fresh) m_fresh = 1'b0;
          else if (note_done) begin
            if (m_idx == 31) m_ph = PH_FINISH;
            else begin
              m_idx++;
              if (play) begin m_ph = PH_LOAD; m_lat = 2; end
              else m_ph = PH_IDLE;
            end
          end
        end
        PH_FINISH: begin e_done = 1'b1; m_ph = PH_OVER; end
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model, plus a log of output pulses.
  always @(negedge clk) begin
    if (chk_on) begin
      check("note", 32'(note), 32'(e_note));
      check("duration", 32'(duration), 32'(e_dur));
      check("new_note", 32'(new_note), 32'(e_new));
      check("song_done", 32'(song_done), 32'(e_done));
      check("pulse_overlap", 32'(new_note & song_done), 32'd0);
      if (new_note) begin
        nn_cyc.push_back(cyc);
        nn_note.push_back(int'(note));
        nn_dur.push_back(int'(duration));
      end
      if (song_done) sd_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    nn_cyc.delete(); nn_note.delete(); nn_dur.delete(); sd_cyc.delete();
  endtask

  task automatic restart(input logic [1:0] s);
    song = s; play = 1'b0; note_done = 1'b0; reset_play = 1'b1;
    step();
    reset_play = 1'b0;
    t0 = cyc;
    clear_log();
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_on = 1'b1;
    check("rst_note", 32'(note), 32'd0);
    check("rst_dur", 32'(duration), 32'd0);
    check("rst_new", 32'(new_note), 32'd0);
    check("rst_done", 32'(song_done), 32'd0);
    repeat (4) step();

    // Song 0: two notes then the end marker.
    restart(2'd0);
    for (int c = 0; c < 26; c++) begin
      play = 1'b1;
      note_done = (c == 6 || c == 12);
      step();
    end
    check("t2_nn_count", 32'(nn_cyc.size()), 32'd2);
    check("t2_sd_count", 32'(sd_cyc.size()), 32'd1);
    if (nn_cyc.size() >= 2) begin
      check("t2_nn0_cyc", 32'(nn_cyc[0] - t0), 32'd3);
      check("t2_nn0_note", 32'(nn_note[0]), 32'h10);
      check("t2_nn0_dur", 32'(nn_dur[0]), 32'd4);
      check("t2_nn1_cyc", 32'(nn_cyc[1] - t0), 32'd9);
      check("t2_nn1_note", 32'(nn_note[1]), 32'h12);
      check("t2_nn1_dur", 32'(nn_dur[1]), 32'd2);
    end
    if (sd_cyc.size() >= 1) check("t2_sd_cyc", 32'(sd_cyc[0] - t0), 32'd16);

    // Async reset in the middle of playing song 2, index 3.
    restart(2'd2);
    for (int c = 0; c < 20; c++) begin
      play = 1'b1;
      note_done = (c == 5 || c == 10 || c == 15);
      step();
    end
    check("t1_note_pre", 32'(note), 32'h15);
    check("t1_dur_pre", 32'(duration), 32'd4);
    play = 1'b0; note_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("t1_note_rst", 32'(note), 32'd0);
    check("t1_dur_rst", 32'(duration), 32'd0);
    check("t1_new_rst", 32'(new_note), 32'd0);
    check("t1_done_rst", 32'(song_done), 32'd0);
    step();
    reset = 1'b0;
    clear_log();
    repeat (8) step();
    check("t1_idle_nn", 32'(nn_cyc.size()), 32'd0);

    // Song 1: all 32 slots, note_done held high throughout.
    restart(2'd1);
    for (int c = 0; c < 150; c++) begin
      play = 1'b1;
      note_done = 1'b1;
      step();
    end
    check("t3_nn_count", 32'(nn_cyc.size()), 32'd32);
    check("t3_sd_count", 32'(sd_cyc.size()), 32'd1);
    if (nn_cyc.size() == 32 && sd_cyc.size() == 1) begin
      check("t3_last_note", 32'(nn_note[31]), 32'd32);
      check("t3_sd_gap", 32'(sd_cyc[0] - nn_cyc[31]), 32'd3);
    end

    // Song 3: play dropped during a note, resumed later at cycle 12.
    restart(2'd3);
    for (int c = 0; c < 19; c++) begin
      play = (c < 4 || c >= 12);
      note_done = (c == 6);
      step();
    end
    check("t4_nn_count", 32'(nn_cyc.size()), 32'd2);
    if (nn_cyc.size() == 2) begin
      check("t4_resume_cyc", 32'(nn_cyc[1] - t0), 32'd15);
      check("t4_resume_note", 32'(nn_note[1]), 32'h31);
    end

    // Song 2 to index 5, then restart on song 3 with a stray note_done.
    restart(2'd2);
    for (int c = 0; c < 35; c++) begin
      if (c < 24) begin play = 1'b1; note_done = 1'b1; end
      else if (c == 24) begin song = 2'd3; reset_play = 1'b1; play = 1'b0; note_done = 1'b0; end
      else begin
        reset_play = 1'b0;
        note_done = (c == 26);
        play = (c >= 29);
      end
      if (c == 27) begin
        check("t5_note_held", 32'(note), 32'h17);
        check("t5_nn_before", 32'(nn_cyc.size()), 32'd6);
      end
      step();
    end
    check("t5_nn_count", 32'(nn_cyc.size()), 32'd7);
    if (nn_cyc.size() == 7) begin
      check("t5_new_cyc", 32'(nn_cyc[6] - t0), 32'd32);
      check("t5_new_note", 32'(nn_note[6]), 32'h30);
      check("t5_new_dur", 32'(nn_dur[6]), 32'd3);
    end

    // reset_play in CHECK, then END held until reset_play.
    restart(2'd0);
    for (int c = 0; c < 39; c++) begin
      play = (c < 2 || c >= 6);
      reset_play = (c == 2 || c == 31);
      note_done = (c == 11 || c == 16 || (c >= 21 && c <= 30));
      if (c == 5) begin
        check("t6_note_hold", 32'(note), 32'h30);
        check("t6_dur_hold", 32'(duration), 32'd3);
        check("t6_no_nn", 32'(nn_cyc.size()), 32'd0);
        check("t6_no_sd", 32'(sd_cyc.size()), 32'd0);
      end
      step();
    end
    reset_play = 1'b0;
    check("t6_nn_count", 32'(nn_cyc.size()), 32'd3);
    check("t6_sd_count", 32'(sd_cyc.size()), 32'd1);
    if (nn_cyc.size() == 3 && sd_cyc.size() == 1) begin
      check("t6_nn0_cyc", 32'(nn_cyc[0] - t0), 32'd9);
      check("t6_nn1_cyc", 32'(nn_cyc[1] - t0), 32'd14);
      check("t6_sd_cyc", 32'(sd_cyc[0] - t0), 32'd20);
      check("t6_exit_cyc", 32'(nn_cyc[2] - t0), 32'd35);
      check("t6_exit_note", 32'(nn_note[2]), 32'h10);
    end

    // Randomized traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      play = ($urandom_range(0, 3) != 0);
      note_done = ($urandom_range(0, 1) == 0);
      reset_play = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) song = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 799) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        step();
      end
    end
    reset_play = 1'b0;
    play = 1'b0;
    note_done = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
